// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields (kind, registers, funct codes,
// signed immediate) into 32-bit instruction words tagged with their byte
// address. It has a single output register, so a new word can be accepted
// in the same cycle the previous one is taken. Immediate range and alignment
// problems are flagged on each word and also collected in a sticky bit.
module instr_encoder #(
   parameter int                width      = 32,
   parameter int                addr_w     = 32,
   parameter logic [addr_w-1:0] reset_addr = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [2:0]              in_kind,
   input  logic [4:0]              in_rd,
   input  logic [4:0]              in_rs1,
   input  logic [4:0]              in_rs2,
   input  logic [2:0]              in_funct3,
   input  logic [6:0]              in_funct7,
   input  logic signed [width-1:0] in_imm,
   input  logic                    addr_load,
   input  logic [addr_w-1:0]       addr_base,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_instr,
   output logic [addr_w-1:0]       out_addr,
   output logic                    out_err,
   output logic                    err_sticky,
   output logic [15:0]             count
);

   // The immediate is widened to at least 21 bits. That leaves room for the
   // widest field (J-type, imm[20:1]) and for its range bounds.
   localparam int IMM_W = (width > 21) ? width : 21;

   localparam logic [2:0] KIND_LOAD   = 3'd0;
   localparam logic [2:0] KIND_STORE  = 3'd1;
   localparam logic [2:0] KIND_BRANCH = 3'd2;
   localparam logic [2:0] KIND_OPIMM  = 3'd3;
   localparam logic [2:0] KIND_JALR   = 3'd4;
   localparam logic [2:0] KIND_JAL    = 3'd5;
   localparam logic [2:0] KIND_OP     = 3'd6;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // Inclusive signed range test on the widened immediate.
   function automatic logic in_range(input logic signed [IMM_W-1:0] v,
                                     input int lo, input int hi);
      return (v >= IMM_W'(lo)) && (v <= IMM_W'(hi));
   endfunction

   function automatic logic [31:0] fmt_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] fmt_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] opc);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
   endfunction

   // Branch offsets are always even, so bit 0 never reaches the word.
   function automatic logic [31:0] fmt_b(input logic [12:1] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] opc);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
   endfunction

   function automatic logic [31:0] fmt_j(input logic [20:1] imm, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
   endfunction

   function automatic logic [31:0] fmt_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] opc);
      return {f7, rs2, rs1, f3, rd, opc};
   endfunction

   logic signed [IMM_W-1:0] imm_x;
   logic                    is_shift;
   logic [31:0]             enc_word;
   logic                    enc_err;
   logic                    accept;
   logic [addr_w-1:0]       pc_base;

   logic              valid_d,  valid_q;
   logic [31:0]       instr_d,  instr_q;
   logic [addr_w-1:0] addr_d,   addr_q;
   logic              err_d,    err_q;
   logic              sticky_d, sticky_q;
   logic [15:0]       count_d,  count_q;
   logic [addr_w-1:0] pc_d,     pc_q;

   assign imm_x    = IMM_W'(in_imm);
   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Encode the fields on the input right now and flag range/alignment errors.
   // Out-of-range immediates are still packed from their low bits.
   always_comb begin
      enc_word = 32'h0000_0000;
      enc_err  = 1'b0;
      is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
      unique case (in_kind)
         KIND_LOAD: begin
            enc_word = fmt_i(imm_x[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD);
            enc_err  = !in_range(imm_x, -2048, 2047);
         end
         KIND_STORE: begin
            enc_word = fmt_s(imm_x[11:0], in_rs2, in_rs1, in_funct3, OPC_STORE);
            enc_err  = !in_range(imm_x, -2048, 2047);
         end
         KIND_BRANCH: begin
            enc_word = fmt_b(imm_x[12:1], in_rs2, in_rs1, in_funct3, OPC_BRANCH);
            enc_err  = !in_range(imm_x, -4096, 4094) || imm_x[0];
         end
         KIND_OPIMM: begin
            if (is_shift) begin
               // Shifts put funct7 in the upper immediate bits, shamt below it.
               enc_word = fmt_i({in_funct7, imm_x[4:0]}, in_rs1, in_funct3, in_rd, OPC_OPIMM);
               enc_err  = !in_range(imm_x, 0, 31);
            end else begin
               enc_word = fmt_i(imm_x[11:0], in_rs1, in_funct3, in_rd, OPC_OPIMM);
               enc_err  = !in_range(imm_x, -2048, 2047);
            end
         end
         KIND_JALR: begin
            enc_word = fmt_i(imm_x[11:0], in_rs1, 3'b000, in_rd, OPC_JALR);
            enc_err  = !in_range(imm_x, -2048, 2047);
         end
         KIND_JAL: begin
            enc_word = fmt_j(imm_x[20:1], in_rd, OPC_JAL);
            enc_err  = !in_range(imm_x, -(1 << 20), (1 << 20) - 2) || imm_x[0];
         end
         KIND_OP: begin
            enc_word = fmt_r(in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP);
         end
         default: begin
            // Reserved kind: emit an all-zero word and flag it.
            enc_word = 32'h0000_0000;
            enc_err  = 1'b1;
         end
      endcase
   end

   // Next state of the output register, program counter, sticky error and count.
   always_comb begin
      valid_d  = valid_q;
      instr_d  = instr_q;
      addr_d   = addr_q;
      err_d    = err_q;
      sticky_d = sticky_q;
      count_d  = count_q;
      pc_d     = pc_q;
      // A word accepted together with addr_load starts the new program region.
      pc_base  = addr_load ? addr_base : pc_q;
      if (accept) begin
         valid_d  = 1'b1;
         instr_d  = enc_word;
         addr_d   = pc_base;
         err_d    = enc_err;
         sticky_d = sticky_q || enc_err;
         count_d  = count_q + 16'd1;
         pc_d     = pc_base + addr_w'(4);
      end else begin
         if (out_ready) begin
            valid_d = 1'b0;
         end
         if (addr_load) begin
            pc_d = addr_base;
         end
      end
   end

   // State registers. Reset takes priority over addr_load and accept, and
   // drops any word still held in the output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         instr_q  <= 32'h0000_0000;
         addr_q   <= '0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
         count_q  <= 16'h0000;
         pc_q     <= reset_addr;
      end else begin
         valid_q  <= valid_d;
         instr_q  <= instr_d;
         addr_q   <= addr_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
         count_q  <= count_d;
         pc_q     <= pc_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_instr  = instr_q;
   assign out_addr   = addr_q;
   assign out_err    = err_q;
   assign err_sticky = sticky_q;
   assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: hand-computed vector table, directed handshake /
// address / reset sequences, and a randomized stream checked against a
// field-placement model with a scoreboard.
module tb_instr_encoder;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [2:0]         in_kind;
   logic [4:0]         in_rd, in_rs1, in_rs2;
   logic [2:0]         in_funct3;
   logic [6:0]         in_funct7;
   logic signed [31:0] in_imm;
   logic               addr_load;
   logic [31:0]        addr_base;
   logic               out_valid;
   logic               out_ready;
   logic [31:0]        out_instr;
   logic [31:0]        out_addr;
   logic               out_err;
   logic               err_sticky;
   logic [15:0]        count;

   always #5 clk = ~clk;

   instr_encoder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .addr_load(addr_load), .addr_base(addr_base),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky), .count(count)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          kind, rd, rs1, rs2, f3, f7, imm;
      logic [31:0] instr;
      bit          err;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
      bit          err;
   } exp_t;

   vec_t        tab[18];
   exp_t        sb[$];
   logic [31:0] m_pc;
   int          m_count;
   bit          m_sticky;
   bit          last_acc;
   int unsigned opc_tab[7] = '{32'h03, 32'h23, 32'h63, 32'h13, 32'h67, 32'h6F, 32'h33};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int unsigned fld(input int unsigned u, input int hi, input int lo);
      return (u >> lo) & ((32'd1 << (hi - lo + 1)) - 1);
   endfunction

   // Reference: place each immediate slice at its documented bit position and
   // judge the range with ordinary integer comparisons.
   function automatic void model_enc(input int kind, input int rd, input int rs1, input int rs2,
                                     input int f3, input int f7, input int imm,
                                     output logic [31:0] w, output bit e);
      int unsigned u, opc, top, f;
      bit odd;
      u   = imm;
      odd = (imm % 2) != 0;
      w   = 0;
      e   = 0;
      opc = (kind < 7) ? opc_tab[kind] : 0;
      case (kind)
         0, 3, 4: begin
            f = (kind == 4) ? 0 : f3;
            if (kind == 3 && (f3 == 1 || f3 == 5)) begin
               top = f7 * 32 + (u % 32);
               e   = imm < 0 || imm > 31;
            end else begin
               top = u % 4096;
               e   = imm < -2048 || imm > 2047;
            end
            w = (top << 20) | (rs1 << 15) | (f << 12) | (rd << 7) | opc;
         end
         1: begin
            w = (fld(u, 11, 5) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
              | (fld(u, 4, 0) << 7) | opc;
            e = imm < -2048 || imm > 2047;
         end
         2: begin
            w = (fld(u, 12, 12) << 31) | (fld(u, 10, 5) << 25) | (rs2 << 20) | (rs1 << 15)
              | (f3 << 12) | (fld(u, 4, 1) << 8) | (fld(u, 11, 11) << 7) | opc;
            e = imm < -4096 || imm > 4094 || odd;
         end
         5: begin
            w = (fld(u, 20, 20) << 31) | (fld(u, 10, 1) << 21) | (fld(u, 11, 11) << 20)
              | (fld(u, 19, 12) << 12) | (rd << 7) | opc;
            e = imm < -(1 << 20) || imm > (1 << 20) - 2 || odd;
         end
         6: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
         default: begin
            w = 0;
            e = 1;
         end
      endcase
   endfunction

   task automatic rand_fields();
      int mode;
      mode      = $urandom_range(3);
      in_kind   = 3'($urandom_range(7));
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_funct3 = 3'($urandom);
      in_funct7 = 7'($urandom);
      case (mode)
         0:       in_imm = $urandom;
         1:       in_imm = int'($urandom_range(10000)) - 5000;
         2:       in_imm = int'($urandom_range(1 << 22)) - (1 << 21);
         default: in_imm = int'($urandom_range(40)) - 4;
      endcase
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      addr_load = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      m_pc     = 32'h0;
      m_count  = 0;
      m_sticky = 1'b0;
   endtask

   // One clock of the stream: compare outputs with the scoreboard mid-cycle,
   // then advance the model by the handshake the spec defines.
   task automatic cycle();
      logic [31:0] w, a;
      bit          e, acc;
      exp_t        x;
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      chk("in_ready", 32'(in_ready), 32'((sb.size() == 0) || out_ready));
      chk("count", 32'(count), m_count & 32'hFFFF);
      chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
      if (sb.size() != 0 && out_valid) begin
         chk("out_instr", out_instr, sb[0].instr);
         chk("out_addr", out_addr, sb[0].addr);
         chk("out_err", 32'(out_err), 32'(sb[0].err));
      end
      acc = 1'b0;
      if (rst) begin
         sb.delete();
         m_pc     = 32'h0;
         m_count  = 0;
         m_sticky = 1'b0;
      end else begin
         acc = in_valid && (sb.size() == 0 || out_ready);
         if (sb.size() != 0 && out_ready) void'(sb.pop_front());
         if (acc) begin
            model_enc(int'(in_kind), int'(in_rd), int'(in_rs1), int'(in_rs2),
                      int'(in_funct3), int'(in_funct7), int'(in_imm), w, e);
            a = addr_load ? addr_base : m_pc;
            x.instr = w;
            x.addr  = a;
            x.err   = e;
            sb.push_back(x);
            m_pc     = a + 32'd4;
            m_count  = m_count + 1;
            m_sticky = m_sticky | e;
         end else if (addr_load) begin
            m_pc = addr_base;
         end
      end
      last_acc = acc;
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit exp_stk;
      int sent;

      //            kind rd rs1 rs2 f3 f7     imm          instr         err
      tab[0]  = '{0, 5, 2, 0, 2, 0,    -4,          32'hFFC12283, 1'b0};
      tab[1]  = '{1, 0, 2, 6, 2, 0,    8,           32'h00612423, 1'b0};
      tab[2]  = '{2, 0, 1, 2, 0, 0,    -8,          32'hFE208CE3, 1'b0};
      tab[3]  = '{5, 1, 0, 0, 0, 0,    2048,        32'h001000EF, 1'b0};
      tab[4]  = '{6, 3, 1, 2, 0, 0,    0,           32'h002081B3, 1'b0};
      tab[5]  = '{3, 1, 0, 0, 0, 0,    2048,        32'h80000093, 1'b1};
      tab[6]  = '{2, 0, 0, 0, 0, 0,    3,           32'h00000163, 1'b1};
      tab[7]  = '{7, 7, 3, 4, 5, 9,    100,         32'h00000000, 1'b1};
      tab[8]  = '{3, 2, 3, 0, 5, 32,   31,          32'h41F1D113, 1'b0};
      tab[9]  = '{3, 1, 1, 0, 1, 0,    32,          32'h00009093, 1'b1};
      tab[10] = '{4, 1, 5, 0, 7, 0,    -1,          32'hFFF280E7, 1'b0};
      tab[11] = '{5, 0, 0, 0, 0, 0,    -(1 << 20),  32'h8000006F, 1'b0};
      tab[12] = '{5, 0, 0, 0, 0, 0,    (1 << 20),   32'h8000006F, 1'b1};
      tab[13] = '{5, 0, 0, 0, 0, 0,    (1 << 20)-2, 32'h7FFFF06F, 1'b0};
      tab[14] = '{2, 0, 0, 0, 0, 0,    4094,        32'h7E000FE3, 1'b0};
      tab[15] = '{2, 0, 0, 0, 0, 0,    4096,        32'h80000063, 1'b1};
      tab[16] = '{1, 0, 0, 0, 0, 0,    -2049,       32'h7E000FA3, 1'b1};
      tab[17] = '{6, 1, 2, 3, 0, 32,   123,         32'h403100B3, 1'b0};

      rst = 1'b1; in_valid = 1'b0; addr_load = 1'b0; addr_base = 32'h0; out_ready = 1'b1;
      in_kind = 3'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
      in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'sd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_addr", out_addr, 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_err_sticky", 32'(err_sticky), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;

      // Hand-computed words, one at a time from address 0.
      exp_stk = 1'b0;
      for (int i = 0; i < 18; i++) begin
         in_kind = 3'(tab[i].kind); in_rd = 5'(tab[i].rd); in_rs1 = 5'(tab[i].rs1);
         in_rs2 = 5'(tab[i].rs2); in_funct3 = 3'(tab[i].f3); in_funct7 = 7'(tab[i].f7);
         in_imm = tab[i].imm; in_valid = 1'b1; out_ready = 1'b1;
         @(negedge clk);
         chk($sformatf("tab%0d_in_ready", i), 32'(in_ready), 32'd1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         exp_stk  = exp_stk | tab[i].err;
         @(negedge clk);
         chk($sformatf("tab%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("tab%0d_instr", i), out_instr, tab[i].instr);
         chk($sformatf("tab%0d_err", i), 32'(out_err), 32'(tab[i].err));
         chk($sformatf("tab%0d_addr", i), out_addr, 32'(i * 4));
         chk($sformatf("tab%0d_count", i), 32'(count), 32'(i + 1));
         chk($sformatf("tab%0d_sticky", i), 32'(err_sticky), 32'(exp_stk));
         @(posedge clk); #1;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("sticky_holds", 32'(err_sticky), 32'd1);
      chk("idle_valid", 32'(out_valid), 32'd0);
      do_reset();
      chk("sticky_cleared", 32'(err_sticky), 32'd0);

      // Back-to-back stream with out_ready low for two cycles.
      sent = 0;
      rand_fields();
      for (int c = 0; c < 12; c++) begin
         in_valid  = (sent < 6);
         out_ready = !(c == 2 || c == 3);
         cycle();
         if (c == 2 || c == 3) begin
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_held_addr", out_addr, 32'd4);
         end
         if (last_acc) begin
            sent++;
            rand_fields();
         end
      end
      chk("bp_count", 32'(count), 32'd6);

      // Program-counter loads and wrap-around.
      do_reset();
      rand_fields(); in_valid = 1'b1; addr_load = 1'b1; addr_base = 32'h100;
      cycle();
      addr_load = 1'b0;
      chk("load_addr", out_addr, 32'h100);
      rand_fields();
      cycle();
      chk("load_next", out_addr, 32'h104);
      in_valid = 1'b0; addr_load = 1'b1; addr_base = 32'h200;
      cycle();
      addr_load = 1'b0; in_valid = 1'b1; rand_fields();
      cycle();
      chk("idle_load_addr", out_addr, 32'h200);
      addr_load = 1'b1; addr_base = 32'hFFFF_FFFC; rand_fields();
      cycle();
      addr_load = 1'b0;
      chk("wrap_top", out_addr, 32'hFFFF_FFFC);
      rand_fields();
      cycle();
      chk("wrap_zero", out_addr, 32'h0);
      in_valid = 1'b0;
      cycle();

      // Reset while a flagged word is stalled at the output.
      rand_fields(); in_kind = 3'd7; in_valid = 1'b1; out_ready = 1'b0;
      cycle();
      chk("stall_sticky", 32'(err_sticky), 32'd1);
      rst = 1'b1; addr_load = 1'b1; addr_base = 32'h300; rand_fields();
      cycle();
      rst = 1'b0; addr_load = 1'b0;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_sticky", 32'(err_sticky), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1; in_valid = 1'b1; rand_fields();
      cycle();
      chk("post_rst_addr", out_addr, 32'h0);
      chk("post_rst_count", 32'(count), 32'd1);
      in_valid = 1'b0;
      cycle();

      // Randomized traffic, including occasional resets and address loads.
      do_reset();
      for (int c = 0; c < 500; c++) begin
         rst       = ($urandom_range(99) == 0);
         in_valid  = ($urandom_range(9) < 7);
         out_ready = ($urandom_range(9) < 7);
         addr_load = ($urandom_range(19) == 0);
         addr_base = $urandom;
         rand_fields();
         cycle();
      end
      rst = 1'b0; in_valid = 1'b0; addr_load = 1'b0; out_ready = 1'b1;
      repeat (3) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
